tt_um_jleugeri_ttt_token_gatherer: RTL and testbench
====================================================

// Module: tt_um_jleugeri_ttt_token_gatherer
// PURPOSE
//  Upstream stage of the ticktocktokens processor core. Turns raw good/bad event pulses into per-tick token counts.
//  - Rising edges on two event pins are counted in saturating accumulators over a programmable tick window.
//  - At each window end the counts become a (new_good_tokens, new_bad_tokens) pair.
//  - The pair is handed to the core through a valid/ready holding register.
// PARAMETERS
//  NEW_TOKENS_BITS  4  width of each token count; must match the core's NEW_TOKENS_BITS
//  TICK_BITS        8  width of the tick-period counter
// PORTS
//  clk               in   1                clock; sole clock domain
//  rst_n             in   1                synchronous, active-low reset
//  good_event_in     in   1                raw good-event pin; each rising edge is one token
//  bad_event_in      in   1                raw bad-event pin; each rising edge is one token
//  tick_period       in   TICK_BITS        window length in cycles; 0 = gatherer disabled
//  new_good_tokens   out  NEW_TOKENS_BITS  good count of the presented window
//  new_bad_tokens    out  NEW_TOKENS_BITS  bad count of the presented window
//  tokens_valid      out  1                holding register holds an unconsumed pair
//  tokens_ready      in   1                core accepts the pair when valid && ready at a clk edge
//  overflow          out  1                sticky: a saturation or a window merge occurred
// BEHAVIOUR
//  Reset (rst_n low at a clk edge):
//   - all outputs, accumulators, edge history and tick counter go to 0
//   - FSM goes to IDLE; reset wins over every other event in the same cycle
//  Edge detect: an edge is registered when the sampled pin is 1 and the previous sample was 0.
//   - an edge counts once, however long the pin stays high
//   - latency from pin sample to accumulator increment: 3 cycles with sync, 1 cycle without
//  Accumulators: +1 per detected edge and saturate at 2^NEW_TOKENS_BITS-1.
//   - an edge arriving while its accumulator is saturated sets overflow
//  FSM:
//   - IDLE: tick_period==0; tick counter held at 0; edges still accumulate.
//     Leaves for RUN when tick_period!=0, loading tick_cnt=tick_period-1.
//   - RUN: tick_cnt decrements each cycle. At tick_cnt==0 it is a window end: reload tick_cnt=tick_period-1.
//     Goes back to IDLE (no window end) when tick_period becomes 0; accumulators are kept.
//   - a tick_period change in RUN takes effect at the next reload
//  Window end, holding register free (!tokens_valid, or tokens_valid && tokens_ready this cycle):
//   - copy accumulators, including this cycle's edge, to the outputs; set tokens_valid=1
//   - clear the accumulators in the same edge
//  Window end, holding register busy (tokens_valid && !tokens_ready):
//   - outputs are not touched
//   - accumulators keep counting, merging this window into the next; overflow is set
//  Handshake:
//   - tokens_valid drops the cycle after acceptance unless a window end reloads it in the same edge
//   - outputs stay stable while tokens_valid && !tokens_ready
//  An edge in the cycle after a window end lands in the new window; tick_period=1 gives a window end every cycle.
//  overflow is cleared only by reset.
// CONFIGURATION
//  TTT_GATHER_SYNC_EN defined:
//   - each event pin passes a 2-FF synchroniser before edge detect
//   - pins may be asynchronous to clk
//  TTT_GATHER_SYNC_EN undefined:
//   - pins feed the edge detector directly; the caller guarantees they are synchronous to clk
//   - all other behaviour is identical
// TESTING
//  1. Reset mid-window with counts present, rst_n=0 one cycle -> all outputs 0, state IDLE the next cycle.
//  2. tick_period=10, 3 good and 2 bad edges, tokens_ready=1 -> pair (3,2) with tokens_valid for one cycle after the window end.
//  3. 20 good edges in one window with NEW_TOKENS_BITS=4 -> new_good_tokens=15, overflow=1.
//  4. tokens_ready=0 over 2 windows of 2 edges each, then ready=1 -> first pair (2,0) held stable; next pair (2,0) from the merged window; overflow=1.
//  5. Pin held high 50 cycles -> exactly 1 token. Edge on the same cycle as the window end -> counted in the current pair.
//  6. tick_period 0->5->0 -> no tokens_valid while 0; accumulators kept; first pair 5 cycles after leaving IDLE.

Source files
------------

// File: rtl/tt_um_jleugeri_ttt_token_gatherer.sv
// tt_um_jleugeri_ttt_token_gatherer: counts good/bad event edges per tick window and presents them via valid/ready.
// Define TTT_GATHER_SYNC_EN to put a 2-FF synchroniser in front of each event pin.
module tt_um_jleugeri_ttt_token_gatherer #(
    parameter int NEW_TOKENS_BITS = 4,
    parameter int TICK_BITS       = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       good_event_in,
    input  logic                       bad_event_in,
    input  logic [TICK_BITS-1:0]       tick_period,
    output logic [NEW_TOKENS_BITS-1:0] new_good_tokens,
    output logic [NEW_TOKENS_BITS-1:0] new_bad_tokens,
    output logic                       tokens_valid,
    input  logic                       tokens_ready,
    output logic                       overflow
);
    typedef enum logic {IDLE, RUN} state_t;
    localparam logic [NEW_TOKENS_BITS-1:0] MAX = '1;

    state_t                     state_q, state_d;
    logic [TICK_BITS-1:0]       tick_q, tick_d;
    logic [1:0]                 pin, prev_q, evt;
    logic [NEW_TOKENS_BITS-1:0] g_acc_q, g_acc_d, b_acc_q, b_acc_d;
    logic [NEW_TOKENS_BITS-1:0] g_out_q, g_out_d, b_out_q, b_out_d;
    logic [NEW_TOKENS_BITS-1:0] g_inc, b_inc;
    logic                       valid_q, valid_d, ovf_q, ovf_d;
    logic                       g_sat, b_sat, wend, take;

`ifdef TTT_GATHER_SYNC_EN
    logic [1:0] s1_q, s2_q;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= {bad_event_in, good_event_in};
            s2_q <= s1_q;
        end
    end
    assign pin = s2_q;
`else
    assign pin = {bad_event_in, good_event_in};
`endif

    assign evt   = pin & ~prev_q;
    assign g_sat = g_acc_q == MAX;
    assign b_sat = b_acc_q == MAX;
    assign g_inc = g_acc_q + NEW_TOKENS_BITS'(evt[0] & ~g_sat);
    assign b_inc = b_acc_q + NEW_TOKENS_BITS'(evt[1] & ~b_sat);
    assign wend  = state_q == RUN && tick_period != '0 && tick_q == '0;
    // A window end only publishes when the holding register is free this edge
    assign take  = wend && (!valid_q || tokens_ready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tick_q  <= '0;
            prev_q  <= '0;
            g_acc_q <= '0;
            b_acc_q <= '0;
            g_out_q <= '0;
            b_out_q <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            prev_q  <= pin;
            g_acc_q <= g_acc_d;
            b_acc_q <= b_acc_d;
            g_out_q <= g_out_d;
            b_out_q <= b_out_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = tick_period == '0 ? IDLE : RUN;
        tick_d  = tick_period == '0 ? '0 :
                  (state_q == IDLE || tick_q == '0) ? tick_period - TICK_BITS'(1) : tick_q - TICK_BITS'(1);
    end

    always_comb begin
        g_acc_d = take ? '0 : g_inc;
        b_acc_d = take ? '0 : b_inc;
        g_out_d = take ? g_inc : g_out_q;
        b_out_d = take ? b_inc : b_out_q;
        valid_d = take ? 1'b1 : valid_q && !tokens_ready;
        ovf_d   = ovf_q | (evt[0] & g_sat) | (evt[1] & b_sat) | (wend & ~take);
    end

    assign new_good_tokens = g_out_q;
    assign new_bad_tokens  = b_out_q;
    assign tokens_valid    = valid_q;
    assign overflow        = ovf_q;
endmodule

// File: tb/tb_tt_um_jleugeri_ttt_token_gatherer.sv
// tb_tt_um_jleugeri_ttt_token_gatherer: directed self-checking bench for the token gatherer (sync disabled).
module tb_tt_um_jleugeri_ttt_token_gatherer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       good_in = 1'b0;
    logic       bad_in = 1'b0;
    logic [7:0] period = '0;
    logic       ready = 1'b0;
    logic [3:0] g_out, b_out;
    logic       valid, ovf;
    int         total = 0;
    int         bad = 0;

    tt_um_jleugeri_ttt_token_gatherer #(.NEW_TOKENS_BITS(4), .TICK_BITS(8)) dut (
        .clk(clk), .rst_n(rst_n), .good_event_in(good_in), .bad_event_in(bad_in),
        .tick_period(period), .new_good_tokens(g_out), .new_bad_tokens(b_out),
        .tokens_valid(valid), .tokens_ready(ready), .overflow(ovf)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic pulses(input int ng, input int nb);
        for (int i = 0; i < ((ng > nb) ? ng : nb); i++) begin
            good_in = i < ng;
            bad_in  = i < nb;
            @(negedge clk);
            good_in = 1'b0;
            bad_in  = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic wait_valid(input int max, output int cycles, output bit got);
        cycles = 0;
        got = 1'b0;
        while (!got && cycles < max) begin
            @(negedge clk);
            cycles++;
            got = valid;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        period = 8'd0;
        repeat (2) @(negedge clk);
        total++; if ({valid, g_out, b_out, ovf} !== 10'd0) begin bad++; $display("FAIL reset_outputs got=%b want=0", {valid, g_out, b_out, ovf}); end
        rst_n = 1'b1;
        pulses(1, 1);
        repeat (5) @(negedge clk);
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_idle_valid got=%b want=0", valid); end
    endtask

    task automatic test_basic();
        int c; bit got;
        period = 8'd10; ready = 1'b1;
        do_reset();
        pulses(3, 2);
        wait_valid(20, c, got);
        total++; if (!got) begin bad++; $display("FAIL basic_timeout got=0 want=1"); end
        total++; if ({g_out, b_out} !== {4'd3, 4'd2}) begin bad++; $display("FAIL basic_pair got=%0d,%0d want=3,2", g_out, b_out); end
        total++; if (c !== 5) begin bad++; $display("FAIL basic_latency got=%0d want=5", c); end
        @(negedge clk);
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL basic_valid_drop got=%b want=0", valid); end
    endtask

    task automatic test_saturate();
        int c; bit got;
        period = 8'd60; ready = 1'b1;
        do_reset();
        pulses(15, 0);
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL sat_early_ovf got=%b want=0", ovf); end
        pulses(5, 0);
        wait_valid(80, c, got);
        total++; if ({got, g_out, b_out} !== {1'b1, 4'd15, 4'd0}) begin bad++; $display("FAIL sat_pair got=%b,%0d,%0d want=1,15,0", got, g_out, b_out); end
        total++; if (ovf !== 1'b1) begin bad++; $display("FAIL sat_ovf got=%b want=1", ovf); end
    endtask

    task automatic test_mid_reset();
        int c; bit got;
        pulses(3, 1);
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk);
        total++; if ({valid, g_out, b_out, ovf} !== 10'd0) begin bad++; $display("FAIL midrst_outputs got=%b want=0", {valid, g_out, b_out, ovf}); end
        rst_n = 1'b1;
        wait_valid(80, c, got);
        total++; if ({got, g_out, b_out, ovf} !== {1'b1, 4'd0, 4'd0, 1'b0}) begin bad++; $display("FAIL midrst_cleared got=%b,%0d,%0d,%b want=1,0,0,0", got, g_out, b_out, ovf); end
    endtask

    task automatic test_backpressure();
        int c; bit got, stable;
        period = 8'd10; ready = 1'b0;
        do_reset();
        pulses(2, 0);
        wait_valid(20, c, got);
        total++; if ({got, g_out, b_out} !== {1'b1, 4'd2, 4'd0}) begin bad++; $display("FAIL bp_first got=%b,%0d,%0d want=1,2,0", got, g_out, b_out); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL bp_ovf_early got=%b want=0", ovf); end
        stable = 1'b1;
        for (int i = 0; i < 12; i++) begin
            good_in = (i == 0 || i == 2);
            @(negedge clk);
            if ({valid, g_out, b_out} !== {1'b1, 4'd2, 4'd0}) stable = 1'b0;
        end
        good_in = 1'b0;
        total++; if (!stable) begin bad++; $display("FAIL bp_stable got=unstable want=held 1,2,0"); end
        total++; if (ovf !== 1'b1) begin bad++; $display("FAIL bp_ovf got=%b want=1", ovf); end
        ready = 1'b1;
        @(negedge clk);
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL bp_accept got=%b want=0", valid); end
        wait_valid(15, c, got);
        total++; if ({got, g_out, b_out} !== {1'b1, 4'd2, 4'd0}) begin bad++; $display("FAIL bp_merged got=%b,%0d,%0d want=1,2,0", got, g_out, b_out); end
    endtask

    task automatic test_edges();
        int c; bit got;
        period = 8'd80; ready = 1'b1;
        do_reset();
        good_in = 1'b1;
        repeat (50) @(negedge clk);
        good_in = 1'b0;
        wait_valid(60, c, got);
        total++; if ({got, g_out, b_out} !== {1'b1, 4'd1, 4'd0}) begin bad++; $display("FAIL held_pin got=%b,%0d,%0d want=1,1,0", got, g_out, b_out); end
        period = 8'd10;
        do_reset();
        repeat (10) @(negedge clk);
        good_in = 1'b1;
        @(negedge clk);
        total++; if ({valid, g_out, b_out} !== {1'b1, 4'd1, 4'd0}) begin bad++; $display("FAIL edge_at_end got=%b,%0d,%0d want=1,1,0", valid, g_out, b_out); end
        good_in = 1'b0; bad_in = 1'b1;
        @(negedge clk);
        bad_in = 1'b0;
        wait_valid(15, c, got);
        total++; if ({got, g_out, b_out} !== {1'b1, 4'd0, 4'd1}) begin bad++; $display("FAIL edge_after_end got=%b,%0d,%0d want=1,0,1", got, g_out, b_out); end
    endtask

    task automatic test_back_to_back();
        period = 8'd1; ready = 1'b1;
        do_reset();
        repeat (2) @(negedge clk);
        total++; if ({valid, g_out, b_out} !== {1'b1, 4'd0, 4'd0}) begin bad++; $display("FAIL b2b_first got=%b,%0d,%0d want=1,0,0", valid, g_out, b_out); end
        good_in = 1'b1;
        @(negedge clk);
        total++; if ({valid, g_out, b_out} !== {1'b1, 4'd1, 4'd0}) begin bad++; $display("FAIL b2b_edge got=%b,%0d,%0d want=1,1,0", valid, g_out, b_out); end
        good_in = 1'b0;
        @(negedge clk);
        total++; if ({valid, g_out, b_out} !== {1'b1, 4'd0, 4'd0}) begin bad++; $display("FAIL b2b_next got=%b,%0d,%0d want=1,0,0", valid, g_out, b_out); end
    endtask

    task automatic test_idle();
        int c; bit got, quiet;
        period = 8'd0; ready = 1'b1;
        do_reset();
        quiet = 1'b1;
        pulses(2, 0);
        repeat (20) begin @(negedge clk); if (valid) quiet = 1'b0; end
        total++; if (!quiet) begin bad++; $display("FAIL idle_quiet got=valid want=no valid"); end
        period = 8'd5;
        wait_valid(20, c, got);
        total++; if (c !== 6) begin bad++; $display("FAIL idle_latency got=%0d want=6", c); end
        total++; if ({got, g_out, b_out} !== {1'b1, 4'd2, 4'd0}) begin bad++; $display("FAIL idle_kept got=%b,%0d,%0d want=1,2,0", got, g_out, b_out); end
        period = 8'd0;
        quiet = 1'b1;
        pulses(1, 0);
        repeat (20) begin @(negedge clk); if (valid) quiet = 1'b0; end
        total++; if (!quiet) begin bad++; $display("FAIL idle_quiet2 got=valid want=no valid"); end
        period = 8'd5;
        wait_valid(20, c, got);
        total++; if ({got, c, g_out, b_out} !== {1'b1, 6, 4'd1, 4'd0}) begin bad++; $display("FAIL idle_rerun got=%b,%0d,%0d,%0d want=1,6,1,0", got, c, g_out, b_out); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturate();
        test_mid_reset();
        test_backpressure();
        test_edges();
        test_back_to_back();
        test_idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
